// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - default parameters and input polarity constants for btn_conditioner
package btn_pkg;

   localparam int DEF_N_CH         = 4;
   localparam int DEF_TICK_DIV     = 50000;
   localparam int DEF_DB_TICKS     = 20;
   localparam int DEF_LONG_TICKS   = 500;
   localparam int DEF_REPEAT_TICKS = 100;

   localparam int POL_ACTIVE_LOW   = 1;
   localparam int POL_ACTIVE_HIGH  = 0;

   // Raw pin value of a button that is not pressed.
   function automatic logic idle_raw(input int active_low);
      return (active_low != POL_ACTIVE_HIGH);
   endfunction

endpackage

// File: rtl/btn_chan.sv
// rtl/btn_chan.sv - one button channel: synchroniser, debounce, hold and optional repeat
// Repeat logic is present only when BTN_REPEAT_EN is defined.
module btn_chan
   import btn_pkg::*;
#(
   parameter int DB_TICKS     = DEF_DB_TICKS,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
   parameter int ACTIVE_LOW   = POL_ACTIVE_LOW
)(
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic btn_raw,
   output logic level,
   output logic press,
   output logic release_stb,
   output logic long_press,
   output logic repeat_stb
);

   localparam int DBW = $clog2(DB_TICKS + 1);
   localparam int HCW = $clog2(LONG_TICKS + 1);
   localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_TICKS - 1);
   localparam logic [HCW-1:0] HC_LAST  = HCW'(LONG_TICKS - 1);
   localparam logic [HCW-1:0] HC_SAT   = HCW'(LONG_TICKS);
   localparam logic           IDLE_RAW = idle_raw(ACTIVE_LOW);

   logic [1:0]     sync;
   logic           s;
   logic [DBW-1:0] db;
   logic [HCW-1:0] hc;
   logic           flip;
   logic           fall;

   assign s    = sync[1] ^ IDLE_RAW;
   assign flip = tick && (s != level) && (db == DB_LAST);
   assign fall = flip && level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync        <= {2{IDLE_RAW}};
         level       <= 1'b0;
         db          <= '0;
         hc          <= '0;
         press       <= 1'b0;
         release_stb <= 1'b0;
         long_press  <= 1'b0;
      end else begin
         sync        <= {sync[0], btn_raw};
         press       <= 1'b0;
         release_stb <= 1'b0;
         long_press  <= 1'b0;
         if (tick) begin
            if (s == level) begin
               db <= '0;
            end else if (db == DB_LAST) begin
               level       <= s;
               db          <= '0;
               press       <= s;
               release_stb <= !s;
            end else begin
               db <= db + 1'b1;
            end
         end
         // The releasing tick wins over a coincident long-press.
         if (!level || fall) begin
            hc <= '0;
         end else if (tick && (hc != HC_SAT)) begin
            hc         <= hc + 1'b1;
            long_press <= (hc == HC_LAST);
         end
      end
   end

`ifdef BTN_REPEAT_EN
   localparam int RCW = $clog2(REPEAT_TICKS + 1);
   localparam logic [RCW-1:0] RC_LAST = RCW'(REPEAT_TICKS - 1);

   logic [RCW-1:0] rc;

   // Counting starts on the tick after long_press, once hc has saturated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rc         <= '0;
         repeat_stb <= 1'b0;
      end else begin
         repeat_stb <= 1'b0;
         if (!level || fall || (hc != HC_SAT)) begin
            rc <= '0;
         end else if (tick) begin
            if (rc == RC_LAST) begin
               rc         <= '0;
               repeat_stb <= 1'b1;
            end else begin
               rc <= rc + 1'b1;
            end
         end
      end
   end
`else
   assign repeat_stb = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N-channel push-button conditioner on a shared sample tick
// Define BTN_REPEAT_EN to enable auto-repeat strobes.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int N_CH         = DEF_N_CH,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int DB_TICKS     = DEF_DB_TICKS,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
   parameter int ACTIVE_LOW   = POL_ACTIVE_LOW
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press,
   output logic [N_CH-1:0] release_stb,
   output logic [N_CH-1:0] long_press,
   output logic [N_CH-1:0] repeat_stb
);

   localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TCW-1:0] TC_LAST = TCW'(TICK_DIV - 1);

   logic [TCW-1:0] tc;
   logic           tick;

   // With TICK_DIV == 1 tc stays at 0 and tick is permanently high.
   assign tick = (tc == TC_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tc <= '0;
      end else if (tick) begin
         tc <= '0;
      end else begin
         tc <= tc + 1'b1;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      btn_chan #(
         .DB_TICKS     (DB_TICKS),
         .LONG_TICKS   (LONG_TICKS),
         .REPEAT_TICKS (REPEAT_TICKS),
         .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .tick        (tick),
         .btn_raw     (btn_raw[i]),
         .level       (level[i]),
         .press       (press[i]),
         .release_stb (release_stb[i]),
         .long_press  (long_press[i]),
         .repeat_stb  (repeat_stb[i])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - self-checking bench for btn_conditioner with an event scoreboard
module tb_btn_conditioner;

   localparam int N_CH = 4;
   localparam int TD   = 4;
   localparam int DB   = 3;
   localparam int LT   = 8;
   localparam int RT   = 4;

   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_LONG  = 2;
   localparam int K_REP   = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N_CH-1:0] btn_raw;
   logic [N_CH-1:0] level;
   logic [N_CH-1:0] press;
   logic [N_CH-1:0] release_stb;
   logic [N_CH-1:0] long_press;
   logic [N_CH-1:0] repeat_stb;

   int ecount = 0;
   int total  = 0;
   int bad    = 0;
   int q[$];

   btn_conditioner #(
      .N_CH         (N_CH),
      .TICK_DIV     (TD),
      .DB_TICKS     (DB),
      .LONG_TICKS   (LT),
      .REPEAT_TICKS (RT),
      .ACTIVE_LOW   (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw),
      .level       (level),
      .press       (press),
      .release_stb (release_stb),
      .long_press  (long_press),
      .repeat_stb  (repeat_stb)
   );

   always #5 clk = ~clk;

   // Edges since reset release: sample ticks fall on edges that are multiples of TD.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ecount <= 0;
      else        ecount <= ecount + 1;
   end

   // Edge at which level flips for a raw change driven just after edge e.
   function automatic int f_edge(input int e);
      return ((e + 3 + TD - 1) / TD) * TD + TD * (DB - 1);
   endfunction

   task automatic push(input int e, input int ch, input int kind);
      int key;
      int i;
      key = e * 16 + ch * 4 + kind;
      i = 0;
      while (i < q.size() && q[i] < key) i++;
      q.insert(i, key);
   endtask

   task automatic push_hold(input int ch, input int e0, input int e1);
      int p;
      int r;
      int lp;
      p  = f_edge(e0);
      r  = f_edge(e1);
      lp = p + TD * LT;
      push(p, ch, K_PRESS);
      if (lp < r) push(lp, ch, K_LONG);
`ifdef BTN_REPEAT_EN
      for (int x = lp + TD * RT; x < r; x += TD * RT) push(x, ch, K_REP);
`endif
      push(r, ch, K_REL);
   endtask

   task automatic see(input int ch, input int kind);
      int act;
      int exp_k;
      act   = ecount * 16 + ch * 4 + kind;
      exp_k = -1;
      if (q.size() != 0) exp_k = q.pop_front();
      total++;
      assert (act === exp_k) else begin
         bad++;
         $error("FAIL strobe: observed edge=%0d ch=%0d kind=%0d, expected key=%0d (edge*16+ch*4+kind, -1=none)",
                ecount, ch, kind, exp_k);
      end
   endtask

   task automatic monitor();
      for (int c = 0; c < N_CH; c++) begin
         if (press[c])       see(c, K_PRESS);
         if (release_stb[c]) see(c, K_REL);
         if (long_press[c])  see(c, K_LONG);
         if (repeat_stb[c])  see(c, K_REP);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         monitor();
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_level"},   int'(level),       0);
      chk({tag, "_press"},   int'(press),       0);
      chk({tag, "_release"}, int'(release_stb), 0);
      chk({tag, "_long"},    int'(long_press),  0);
      chk({tag, "_repeat"},  int'(repeat_stb),  0);
   endtask

   initial begin
      rst_n   = 1'b0;
      btn_raw = '1;
      adv(3);
      chk_all_zero("reset");
      rst_n = 1'b1;
      adv(100);
      chk_all_zero("idle");

      // clean press/release on ch0
      push_hold(0, ecount, ecount + 16);
      btn_raw[0] = 1'b0;
      adv(16);
      chk("ch0_level_hi", int'(level), 4'b0001);
      btn_raw[0] = 1'b1;
      adv(16);
      chk("ch0_level_lo", int'(level), 0);

      // 2-tick glitch on ch1 is rejected
      btn_raw[1] = 1'b0;
      adv(8);
      btn_raw[1] = 1'b1;
      adv(20);
      chk("ch1_glitch_level", int'(level), 0);

      // 3-tick pulse on ch1 is accepted
      push_hold(1, ecount, ecount + 12);
      btn_raw[1] = 1'b0;
      adv(12);
      btn_raw[1] = 1'b1;
      adv(20);
      chk("ch1_pulse_level", int'(level), 0);

      // 30-tick hold on ch2: press, long-press, repeats, release
      push_hold(2, ecount, ecount + 120);
      btn_raw[2] = 1'b0;
      adv(60);
      chk("ch2_held_level", int'(level), 4'b0100);
      adv(60);
      btn_raw[2] = 1'b1;
      adv(20);
      chk("ch2_released_level", int'(level), 0);

      // simultaneous press on ch0 and ch3
      push_hold(0, ecount, ecount + 20);
      push_hold(3, ecount, ecount + 20);
      btn_raw = 4'b0110;
      adv(20);
      chk("ch03_level_hi", int'(level), 4'b1001);
      btn_raw = '1;
      adv(20);
      chk("ch03_level_lo", int'(level), 0);

      // reset while ch2 is held: no release, single new press afterwards
      push(f_edge(ecount), 2, K_PRESS);
      btn_raw[2] = 1'b0;
      adv(24);
      chk("ch2_pre_reset_level", int'(level), 4'b0100);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midhold");
      adv(3);
      rst_n = 1'b1;
      push_hold(2, ecount, ecount + 60);
      adv(60);
      btn_raw[2] = 1'b1;
      adv(20);
      chk("ch2_post_reset_level", int'(level), 0);

      chk("scoreboard_drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Parametrised N-channel push-button conditioner: synchronises raw board buttons, debounces them on a shared sample tick, and produces clean levels plus one-cycle press, release and long-press strobes. Optionally adds auto-repeat strobes while a button is held. Sits between the board `btn` pins and the game FSM, replacing the per-button debouncer instances and the separate divided clock: everything runs on the board clock, and the tick is only a clock enable.

## Interface
- `N_CH`, 4: number of button channels.
- `TICK_DIV`, 50000: board-clock cycles per sample tick (≥1).
- `DB_TICKS`, 20: consecutive differing ticks required to flip a level (≥1).
- `LONG_TICKS`, 500: held ticks before the long-press strobe (≥1).
- `REPEAT_TICKS`, 100: ticks between repeat strobes. Used only with `BTN_REPEAT_EN`.
- `ACTIVE_LOW`, 1: 1 means a raw input of 0 is "pressed".
- `clk`, in, 1: board clock.
- `rst_n`, in, 1: **asynchronous, active-low reset.**
- `btn_raw`, in, N_CH: asynchronous raw button pins.
- `level`, out, N_CH: debounced pressed state, 1 = pressed.
- `press`, out, N_CH: one-cycle strobe when `level` rises.
- `release`, out, N_CH: one-cycle strobe when `level` falls.
- `long_press`, out, N_CH: one-cycle strobe after a hold of `LONG_TICKS` ticks.
- `repeat`, out, N_CH: one-cycle strobe for auto-repeat. Tied to 0 without `BTN_REPEAT_EN`.

## Operation
- **Tick counter.** Counts 0..TICK_DIV-1. `tick` is high in the cycle the count equals TICK_DIV-1, then the count wraps to 0. With `TICK_DIV`=1, `tick` is high every cycle.
- **Synchroniser.** Per channel, 2 flops, clocked every cycle. Polarity is corrected after the synchroniser, so `s` is the logical pressed value.
- **Debounce counter `db`** (width $clog2(DB_TICKS+1)), evaluated only on ticks:
  - If `s == level`: `db` ← 0.
  - Else if `db == DB_TICKS-1`: `level` ← `s`, `db` ← 0, and the `press` or `release` strobe is registered on the same edge.
  - Else: `db` ← `db`+1.
  - A glitch lasting fewer than `DB_TICKS` consecutive ticks never changes `level`.
- **Hold counter `hc`** (saturating, width $clog2(LONG_TICKS+1)):
  - Cleared whenever `level` = 0.
  - Incremented on each tick while `level` = 1.
  - `long_press` pulses for one cycle on the tick where `hc` reaches LONG_TICKS. It then saturates: one long-press per hold.
- **Repeat** (macro only). After `long_press`, a repeat counter pulses `repeat` every `REPEAT_TICKS` ticks until release. The first repeat occurs REPEAT_TICKS ticks after `long_press`, not coincident with it.
- **Channel independence.** Channels are fully independent. Simultaneous events on several channels produce simultaneous strobes.
- **Release.** Release immediately ends long/repeat activity. `press`, `long_press` and `repeat` are never asserted in the same cycle as `release` on the same channel.

## Timing
- **Reset values.** During/after reset, all outputs are 0. Tick counter = 0. Synchroniser flops hold the "released" raw value (1 if `ACTIVE_LOW`). All channel counters are 0.
- **Reset mid-hold.** Produces no `release` strobe. If the button is still held after reset, `level` rises again through the normal debounce path and `press` strobes once.
- **Latency.** `btn_raw` edge → `s` after 2 clocks. `level` changes on the edge at the end of the DB_TICKS-th consecutive tick with `s ≠ level`. Worst case is 2 + DB_TICKS·TICK_DIV clocks.
- **Strobe alignment.** All strobes are registered, exactly one `clk` cycle wide, and aligned with the `level` update or the counter event that causes them.

## Configuration
- `BTN_REPEAT_EN` defined: the repeat counter (width $clog2(REPEAT_TICKS+1)) and the `repeat` output logic are compiled in.
- `BTN_REPEAT_EN` undefined: no repeat registers exist, and `repeat` is constant 0. All other behaviour is identical.

## Structure
- **Package `btn_pkg`:** default parameter constants and the `ACTIVE_LOW` polarity constants.
- **Top `btn_conditioner`:** tick counter plus a generate loop over channels.
- **Sub-module `btn_chan`:** one per channel, containing the synchroniser, debounce, hold and repeat logic, driven by a shared `tick` enable.

## Test plan
Parameters: TICK_DIV=4, DB_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=4, `BTN_REPEAT_EN` on, N_CH=4.
- **Reset.** Hold `rst_n`=0 with `btn_raw`=4'hF, release reset, idle 100 clocks → all outputs stay 0.
- **Clean press/release.** Drive ch0 raw low → `level[0]`=1 with one `press[0]` pulse within 2+12 clocks. Then drive raw high → one `release[0]` pulse and `level[0]`=0 within 14 clocks.
- **Glitch rejection.** Low pulse on ch1 lasting 2 ticks (8 clocks) → no change on any ch1 output. A 3-tick-stable pulse → `press[1]` asserted.
- **Long-press and repeat.** Hold ch2 for 30 ticks → `press`, then `long_press` 8 ticks after `level` rises, then `repeat` at +4, +8, +12… ticks. Release → `release[2]` and no further `repeat`.
- **Simultaneous events.** Press ch0 and ch3 on the same clock → identical-cycle `press[0]` and `press[3]`.
- **Reset mid-hold.** Assert `rst_n` low during the ch2 hold → outputs 0 immediately, no `release`. Deassert with ch2 still held → a single new `press[2]` after debounce.
